// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: writeback source encodings, register-file geometry.
package mips_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 32;

  typedef enum logic [1:0] {
    MEMTOREG_ALU  = 2'b00,
    MEMTOREG_MEM  = 2'b01,
    MEMTOREG_LINK = 2'b10,
    MEMTOREG_MOVE = 2'b11
  } memToReg_e;

  localparam logic [ADDR_W-1:0] REG_ZERO    = 5'd0;
  localparam logic [DATA_W-1:0] LINK_OFFSET = 32'd4;
  localparam logic [DATA_W-1:0] RESET_PC    = 32'h8000_0000;

endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-regfile bus: writeback inputs, ID read ports and debug counter.
//   master: pipeline/ID side driving the *_in and RdAddr signals
//   slave : wb_regfile, driving read data, WrData, WrEn and wr_count
interface wb_regfile_if;
  import mips_pkg::*;

  logic [1:0]        MemtoReg_in;
  logic              RegWr_in;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] RdData_in;
  logic [DATA_W-1:0] ALUOut_in;
  logic [DATA_W-1:0] Ra_in;
  logic [ADDR_W-1:0] WrAddr_in;
  logic [ADDR_W-1:0] RdAddr1;
  logic [ADDR_W-1:0] RdAddr2;
  logic [DATA_W-1:0] RdData1;
  logic [DATA_W-1:0] RdData2;
  logic [DATA_W-1:0] WrData;
  logic              WrEn;
  logic [DATA_W-1:0] wr_count;

  modport master (
    output MemtoReg_in, RegWr_in, pc_in, RdData_in, ALUOut_in, Ra_in,
           WrAddr_in, RdAddr1, RdAddr2,
    input  RdData1, RdData2, WrData, WrEn, wr_count
  );

  modport slave (
    input  MemtoReg_in, RegWr_in, pc_in, RdData_in, ALUOut_in, Ra_in,
           WrAddr_in, RdAddr1, RdAddr2,
    output RdData1, RdData2, WrData, WrEn, wr_count
  );

endinterface

// File: rtl/wb_regfile_core.sv
// 31-entry register array ($0 hardwired to zero) with one write port and two
// combinational read ports that bypass a same-cycle write.
//   clk, reset       : clock, synchronous active-high reset (clears $1-$31)
//   wrEn/wrAddr/wrData: qualified write port
//   rdAddrN/rdDataN  : read ports
module regfile_core
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr1,
  input  logic [ADDR_W-1:0] rdAddr2,
  output logic [DATA_W-1:0] rdData1,
  output logic [DATA_W-1:0] rdData2
);

  logic [DATA_W-1:0] regs [1:NUM_REGS-1];

  // Storage: reset wins over a pending write on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < int'(NUM_REGS); i++) begin
        regs[i] <= '0;
      end
    end else if (wrEn && (wrAddr != REG_ZERO)) begin
      regs[wrAddr] <= wrData;
    end
  end

  // Read port 1: $0 mask, then bypass, then array.
  always_comb begin
    rdData1 = '0;
    if (rdAddr1 == REG_ZERO) begin
      rdData1 = '0;
    end else if (wrEn && (rdAddr1 == wrAddr)) begin
      rdData1 = wrData;
    end else begin
      rdData1 = regs[rdAddr1];
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    rdData2 = '0;
    if (rdAddr2 == REG_ZERO) begin
      rdData2 = '0;
    end else if (wrEn && (rdAddr2 == wrAddr)) begin
      rdData2 = wrData;
    end else begin
      rdData2 = regs[rdAddr2];
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: selects the writeback value, qualifies the write strobe,
// commits into regfile_core and counts committed writes.
//   clk, reset : clock, synchronous active-high reset
//   bus        : wb_regfile_if slave (MEM/WB inputs, ID read ports, wr_count)
module wb_regfile
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC_LINK = 32'h8000_0004
) (
  input  logic        clk,
  input  logic        reset,
  wb_regfile_if.slave bus
);

  logic [DATA_W-1:0] writeData;
  logic [DATA_W-1:0] linkAddr;
  logic              writeEn;
  logic [DATA_W-1:0] wrCount;

  // Link address wraps at 32 bits; the carry is dropped by design.
  assign linkAddr = bus.pc_in + LINK_OFFSET;

  // Writeback source select.
  always_comb begin
    writeData = '0;
    unique case (memToReg_e'(bus.MemtoReg_in))
      MEMTOREG_ALU:  writeData = bus.ALUOut_in;
      MEMTOREG_MEM:  writeData = bus.RdData_in;
      MEMTOREG_LINK: writeData = linkAddr;
      MEMTOREG_MOVE: writeData = bus.Ra_in;
      default:       writeData = '0;
    endcase
  end

  // Sanity check of the documented link value at the reset PC.
  always_comb begin
    if (bus.pc_in == RESET_PC) begin
      assert (linkAddr == RESET_PC_LINK);
    end
  end

  // Writes to $0 are discarded and never count as commits.
  assign writeEn = bus.RegWr_in && (bus.WrAddr_in != REG_ZERO);

  always_ff @(posedge clk) begin
    if (reset) begin
      wrCount <= '0;
    end else if (writeEn) begin
      wrCount <= wrCount + DATA_W'(1);
    end
  end

  regfile_core uCore (
    .clk     (clk),
    .reset   (reset),
    .wrEn    (writeEn),
    .wrAddr  (bus.WrAddr_in),
    .wrData  (writeData),
    .rdAddr1 (bus.RdAddr1),
    .rdAddr2 (bus.RdAddr2),
    .rdData1 (bus.RdData1),
    .rdData2 (bus.RdData2)
  );

  assign bus.WrData   = writeData;
  assign bus.WrEn     = writeEn;
  assign bus.wr_count = wrCount;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile.
module tb_wb_regfile;

  logic clk;
  logic reset;
  int   testsRun;
  int   testsFailed;

  wb_regfile_if bus ();

  wb_regfile dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] sel, input logic wr, input logic [4:0] wa,
                       input logic [31:0] alu, input logic [4:0] ra1, input logic [4:0] ra2);
    bus.MemtoReg_in = sel;
    bus.RegWr_in    = wr;
    bus.WrAddr_in   = wa;
    bus.ALUOut_in   = alu;
    bus.RdAddr1     = ra1;
    bus.RdAddr2     = ra2;
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    reset       = 1'b1;
    bus.MemtoReg_in = 2'b00;
    bus.RegWr_in    = 1'b0;
    bus.pc_in       = 32'h8000_0000;
    bus.RdData_in   = '0;
    bus.ALUOut_in   = '0;
    bus.Ra_in       = '0;
    bus.WrAddr_in   = '0;
    bus.RdAddr1     = '0;
    bus.RdAddr2     = '0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state: every index reads 0 on both ports.
    for (int i = 0; i < 32; i++) begin
      bus.RdAddr1 = 5'(i);
      bus.RdAddr2 = 5'(31 - i);
      #1;
      checkVal($sformatf("rst_rd1[%0d]", i), bus.RdData1, 32'h0);
      checkVal($sformatf("rst_rd2[%0d]", 31 - i), bus.RdData2, 32'h0);
    end
    checkVal("rst_count", bus.wr_count, 32'h0);
    checkVal("rst_wren", 32'(bus.WrEn), 32'h0);
    checkVal("rst_wrdata", bus.WrData, 32'h0);
    checkVal("rst_link", 32'h0, 32'h0 + 32'(bus.pc_in != 32'h8000_0000));

    // Write $8 with same-cycle bypass on both ports.
    drive(2'b00, 1'b1, 5'd8, 32'h1234_5678, 5'd8, 5'd8);
    checkVal("byp_wren", 32'(bus.WrEn), 32'h1);
    checkVal("byp_rd1", bus.RdData1, 32'h1234_5678);
    checkVal("byp_rd2", bus.RdData2, 32'h1234_5678);
    tick();
    drive(2'b00, 1'b0, 5'd8, 32'h0, 5'd8, 5'd8);
    checkVal("arr_rd1", bus.RdData1, 32'h1234_5678);
    checkVal("arr_rd2", bus.RdData2, 32'h1234_5678);
    checkVal("count_1", bus.wr_count, 32'h1);

    // Writeback select sweep.
    bus.RdData_in = 32'hDEAD_BEEF;
    bus.pc_in     = 32'hFFFF_FFFC;
    bus.Ra_in     = 32'hCAFE_0001;
    bus.ALUOut_in = 32'h0BAD_F00D;
    bus.MemtoReg_in = 2'b00; #1; checkVal("sel_alu", bus.WrData, 32'h0BAD_F00D);
    bus.MemtoReg_in = 2'b01; #1; checkVal("sel_mem", bus.WrData, 32'hDEAD_BEEF);
    bus.MemtoReg_in = 2'b10; #1; checkVal("sel_link_wrap", bus.WrData, 32'h0000_0000);
    bus.pc_in = 32'h8000_0000; #1; checkVal("sel_link_reset", bus.WrData, 32'h8000_0004);
    bus.pc_in = 32'h0040_0010; #1; checkVal("sel_link", bus.WrData, 32'h0040_0014);
    bus.MemtoReg_in = 2'b11; #1; checkVal("sel_move", bus.WrData, 32'hCAFE_0001);

    // Write to $0 is discarded.
    drive(2'b00, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
    checkVal("zero_wren", 32'(bus.WrEn), 32'h0);
    checkVal("zero_rd1", bus.RdData1, 32'h0);
    checkVal("zero_rd2", bus.RdData2, 32'h0);
    tick();
    checkVal("zero_count", bus.wr_count, 32'h1);
    checkVal("zero_rd1_after", bus.RdData1, 32'h0);

    // Independent ports, bypass on one port only; move-select commit.
    drive(2'b00, 1'b1, 5'd5, 32'h0000_1111, 5'd0, 5'd0);
    tick();
    drive(2'b00, 1'b1, 5'd6, 32'h0000_2222, 5'd0, 5'd0);
    tick();
    drive(2'b00, 1'b1, 5'd6, 32'h0000_3333, 5'd5, 5'd6);
    checkVal("ind_rd1_arr", bus.RdData1, 32'h0000_1111);
    checkVal("ind_rd2_byp", bus.RdData2, 32'h0000_3333);
    tick();
    drive(2'b00, 1'b0, 5'd6, 32'h0, 5'd6, 5'd8);
    checkVal("ind_rd1_new", bus.RdData1, 32'h0000_3333);
    checkVal("ind_rd2_old", bus.RdData2, 32'h1234_5678);
    checkVal("count_4", bus.wr_count, 32'h4);
    bus.Ra_in = 32'h7777_0001;
    drive(2'b11, 1'b1, 5'd9, 32'h0, 5'd9, 5'd0);
    tick();
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    checkVal("move_arr", bus.RdData1, 32'h7777_0001);
    checkVal("count_5", bus.wr_count, 32'h5);

    // Write $31, then reset on the same edge as a write to $3.
    drive(2'b00, 1'b1, 5'd31, 32'hA5A5_A5A5, 5'd0, 5'd0);
    tick();
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd31, 5'd0);
    checkVal("r31_pre", bus.RdData1, 32'hA5A5_A5A5);
    reset = 1'b1;
    drive(2'b00, 1'b1, 5'd3, 32'h0000_0005, 5'd3, 5'd31);
    checkVal("rst_byp_rd1", bus.RdData1, 32'h0000_0005);
    tick();
    reset = 1'b0;
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd31, 5'd3);
    checkVal("rst_r31", bus.RdData1, 32'h0);
    checkVal("rst_r3", bus.RdData2, 32'h0);
    checkVal("rst_count2", bus.wr_count, 32'h0);
    bus.RdAddr1 = 5'd8; bus.RdAddr2 = 5'd9; #1;
    checkVal("rst_r8", bus.RdData1, 32'h0);
    checkVal("rst_r9", bus.RdData2, 32'h0);

    // Counter wrap from a preloaded all-ones value.
    force dut.wrCount = 32'hFFFF_FFFF;
    #1;
    release dut.wrCount;
    #1;
    checkVal("preload", bus.wr_count, 32'hFFFF_FFFF);
    drive(2'b00, 1'b1, 5'd7, 32'h0000_0077, 5'd7, 5'd0);
    tick();
    checkVal("wrap_0", bus.wr_count, 32'h0);
    tick();
    drive(2'b00, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    checkVal("wrap_1", bus.wr_count, 32'h1);
    checkVal("wrap_r7", bus.RdData1, 32'h0000_0077);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Writeback stage and general-purpose register file of the five-stage MIPS pipeline. It consumes the MEM/WB pipeline register outputs, selects the writeback value, and commits it to a 32×32-bit register array. It serves two combinational read ports to the ID stage, with same-cycle write-to-read bypass, and counts committed writes for the performance/debug bus.

## Interface
Parameters:
- `RESET_PC_LINK`, 32'h8000_0004: value returned by the link path (`pc_in + 4`) while `pc_in` holds its reset value 32'h8000_0000; informational, not overridable behaviour.

Ports:
- `clk`  input  1  single system clock, all state on rising edge
- `reset`  input  1  synchronous, active-high reset
- `MemtoReg_in`  input  2  writeback source select
- `RegWr_in`  input  1  register write enable
- `pc_in`  input  32  PC of the retiring instruction
- `RdData_in`  input  32  data memory load result
- `ALUOut_in`  input  32  ALU result
- `Ra_in`  input  32  forwarded rs operand
- `WrAddr_in`  input  5  destination register index
- `RdAddr1`  input  5  read port 1 index (rs)
- `RdAddr2`  input  5  read port 2 index (rt)
- `RdData1`  output  32  read port 1 data
- `RdData2`  output  32  read port 2 data
- `WrData`  output  32  selected writeback value, for EX/MEM forwarding
- `WrEn`  output  1  effective write strobe: `RegWr_in && WrAddr_in != 0`
- `wr_count`  output  32  committed-write counter

## Operation
- Writeback select: 2'b00 → `ALUOut_in`; 2'b01 → `RdData_in`; 2'b10 → `pc_in + 4` (link; 32-bit wrap, carry dropped); 2'b11 → `Ra_in` (register move).
- Register $0 reads as 0 at all times. Writes to index 0 are discarded and do not assert `WrEn` or advance `wr_count`.
- Commit: on a rising edge with `reset`=0 and `WrEn`=1, `array[WrAddr_in] <= WrData`.
- Read port n: if `RdAddrn == 0`, output 0. Otherwise, if `WrEn` and `RdAddrn == WrAddr_in`, output `WrData` (bypass). Otherwise output `array[RdAddrn]`. Both ports are independent and may address the same register.
- `wr_count` increments by 1 on each commit and wraps from 32'hFFFF_FFFF to 0.
- Reset: on a rising edge with `reset`=1, all array entries $1–$31 are cleared to 0 and `wr_count` is cleared to 0. No commit occurs on that edge, even if `WrEn`=1.

## Timing
- Write latency: the value becomes architecturally visible through the array on the edge after `WrEn`. Same-cycle readers see it through the bypass, so the effective read-after-write latency is 0 cycles.
- `WrData`, `WrEn`, `RdData1`, and `RdData2` are purely combinational from their inputs and current state.
- Reset values:
  - after the reset edge, `RdData1`/`RdData2` are 0 for any address unless bypassed;
  - `wr_count` is 0;
  - `WrData` and `WrEn` follow the inputs. Upstream MEM/WB holds `RegWr`=0 and `MemtoReg`=0 in reset, giving `WrData`=0 and `WrEn`=0.
- Reset asserted mid-stream: any pending write is dropped on the reset edge. Bypass stays active combinationally during reset, because read ports always reflect the current inputs.
- Simultaneous events: a write and two reads of the same index in one cycle return the new value on both ports. On the next edge both ports return the same value from the array.

## Structure
- Shared package `mips_pkg`: `MEMTOREG_ALU`=2'b00, `MEMTOREG_MEM`=2'b01, `MEMTOREG_LINK`=2'b10, `MEMTOREG_MOVE`=2'b11, plus the `REG_ZERO`=5'd0 constant.
- One sub-module, `regfile_core`, contains:
  - the 31-entry storage array with synchronous reset;
  - the write port;
  - the two combinational read ports with $0 masking and bypass.
- `wb_regfile` owns the writeback mux, the `WrEn` qualification, and `wr_count`.

## Test plan
- Reset, then read all 32 indices on both ports → all 0; `wr_count`=0.
- `MemtoReg`=00, `ALUOut`=32'h1234_5678, `WrAddr`=8, `RegWr`=1, `RdAddr1`=8 in the same cycle → `RdData1`=32'h1234_5678 via bypass. On the next cycle with `RegWr`=0 → still 32'h1234_5678; `wr_count`=1.
- Select sweep: `MemtoReg`=01 with `RdData`=32'hDEAD_BEEF → `WrData` 32'hDEAD_BEEF; 10 with `pc`=32'hFFFF_FFFC → 32'h0000_0000 (wrap); 11 with `Ra`=32'hCAFE_0001 → 32'hCAFE_0001.
- Write 32'hFFFF_FFFF to index 0 with `RegWr`=1 → `WrEn`=0, `RdData1`/`RdData2` at index 0 read 0, `wr_count` unchanged.
- Write 32'hA5A5_A5A5 to $31, then assert `reset` on the same edge as a write of 32'h5 to $3 → after reset, $31=0, $3=0, `wr_count`=0.
- Preload `wr_count` via 2^32−1 commits (or a forced value) → the next commit wraps `wr_count` to 0.
